alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 188 ++++++++++++++++++
 tb/tb_alu_issue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ALU issue stage: buffers requests, decodes op into ALU drives and keeps the {C,V,Z} flag register.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered ready_o.
module alu_issue (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  op_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] inA_o,
  output logic [63:0] inB_o,
  output logic        cflag_o,
  output logic        sum_en_o,
  output logic        and_en_o,
  output logic        xor_en_o,
  input  logic        alu_cflag_i,
  input  logic        alu_vflag_i,
  input  logic        alu_zflag_i,
  output logic [2:0]  flags_o
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_CMP   = 4'd8;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_op_q, out_op_d;
  logic [63:0] out_a_q, out_a_d;
  logic [63:0] out_b_q, out_b_d;
  logic [2:0]  flags_q, flags_d;
  logic        accept, issue;

  assign accept  = valid_i & ready_o;
  assign issue   = out_valid_q & ready_i;
  assign valid_o = out_valid_q;
  assign flags_o = flags_q;

`ifdef ALU_ISSUE_SKID_EN
  logic        sk_valid_q, sk_valid_d;
  logic [3:0]  sk_op_q, sk_op_d;
  logic [63:0] sk_a_q, sk_a_d;
  logic [63:0] sk_b_q, sk_b_d;
  logic        ready_q;

  assign ready_o = ready_q;

  // Skid entry only fills while the output register is stalled; it drains first to keep order.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    sk_valid_d  = sk_valid_q;
    sk_op_d     = sk_op_q;
    sk_a_d      = sk_a_q;
    sk_b_d      = sk_b_q;
    if (!out_valid_q || ready_i) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_op_d    = sk_op_q;
        out_a_d     = sk_a_q;
        out_b_d     = sk_b_q;
        sk_valid_d  = accept;
        if (accept) begin
          sk_op_d = op_i;
          sk_a_d  = a_i;
          sk_b_d  = b_i;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_op_d = op_i;
          out_a_d  = a_i;
          out_b_d  = b_i;
        end
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_op_d    = op_i;
      sk_a_d     = a_i;
      sk_b_d     = b_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sk_valid_q <= 1'b0;
      sk_op_q    <= '0;
      sk_a_q     <= '0;
      sk_b_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      sk_valid_q <= sk_valid_d;
      sk_op_q    <= sk_op_d;
      sk_a_q     <= sk_a_d;
      sk_b_q     <= sk_b_d;
      ready_q    <= ~sk_valid_d;
    end
  end
`else
  logic rst_done_q;

  assign ready_o = rst_done_q & (~out_valid_q | ready_i);

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    if (!out_valid_q || ready_i) begin
      out_valid_d = accept;
      if (accept) begin
        out_op_d = op_i;
        out_a_d  = a_i;
        out_b_d  = b_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_done_q <= 1'b0;
    else           rst_done_q <= 1'b1;
  end
`endif

  always_comb begin
    flags_d = flags_q;
    if (issue) begin
      case (out_op_q)
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP:
          flags_d = {alu_cflag_i, alu_vflag_i, alu_zflag_i};
        OP_AND, OP_OR, OP_XOR, OP_PASSA:
          flags_d[0] = alu_zflag_i;
        default: flags_d = flags_q;
      endcase
    end
  end

  // Carry-in reads the live flag register so a dependent ADC/SBC sees the prior op's C.
  always_comb begin
    inA_o    = '0;
    inB_o    = '0;
    cflag_o  = 1'b0;
    sum_en_o = 1'b0;
    and_en_o = 1'b0;
    xor_en_o = 1'b0;
    if (out_valid_q) begin
      inA_o = out_a_q;
      case (out_op_q)
        OP_ADD:         begin sum_en_o = 1'b1; inB_o = out_b_q; end
        OP_ADC:         begin sum_en_o = 1'b1; inB_o = out_b_q; cflag_o = flags_q[2]; end
        OP_SUB, OP_CMP: begin sum_en_o = 1'b1; inB_o = ~out_b_q; cflag_o = 1'b1; end
        OP_SBC:         begin sum_en_o = 1'b1; inB_o = ~out_b_q; cflag_o = flags_q[2]; end
        OP_AND:         begin and_en_o = 1'b1; inB_o = out_b_q; end
        OP_OR:          begin and_en_o = 1'b1; xor_en_o = 1'b1; inB_o = out_b_q; end
        OP_XOR:         begin xor_en_o = 1'b1; inB_o = out_b_q; end
        OP_PASSA:       begin and_en_o = 1'b1; inB_o = '1; end
        default:        inA_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed requests push expected drives, a monitor checks each presented op.
module tb_alu_issue;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [3:0]  op_i;
  logic [63:0] a_i, b_i, inA_o, inB_o;
  logic        cflag_o, sum_en_o, and_en_o, xor_en_o;
  logic        alu_cflag_i, alu_vflag_i, alu_zflag_i;
  logic [2:0]  flags_o;

  alu_issue dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .inA_o(inA_o), .inB_o(inB_o), .cflag_o(cflag_o), .sum_en_o(sum_en_o),
    .and_en_o(and_en_o), .xor_en_o(xor_en_o), .alu_cflag_i(alu_cflag_i),
    .alu_vflag_i(alu_vflag_i), .alu_zflag_i(alu_zflag_i), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] ea;
    logic [63:0] eb;
    logic        cin;
    logic [2:0]  en;
    logic [2:0]  alu;
    logic [2:0]  fl;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   pend = 0;
  logic [2:0] pend_fl;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (pend) begin
        chk("flags_after_issue", {61'd0, flags_o}, {61'd0, pend_fl});
        pend = 0;
      end
      if (valid_o) begin
        if (sbq.size() == 0) begin
          chk("no_stale_issue", {63'd0, valid_o}, 64'd0);
        end else begin
          mon_e = sbq[0];
          {alu_cflag_i, alu_vflag_i, alu_zflag_i} = mon_e.alu;
          chk("inA", inA_o, mon_e.ea);
          chk("inB", inB_o, mon_e.eb);
          chk("cin", {63'd0, cflag_o}, {63'd0, mon_e.cin});
          chk("enables", {61'd0, sum_en_o, and_en_o, xor_en_o}, {61'd0, mon_e.en});
          if (ready_i) begin
            void'(sbq.pop_front());
            pend    = 1;
            pend_fl = mon_e.fl;
          end
        end
      end else begin
        chk("idle_enables", {61'd0, sum_en_o, and_en_o, xor_en_o}, 64'd0);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] ea, input logic [63:0] eb, input logic ecin,
                      input logic [2:0] een, input logic [2:0] alu, input logic [2:0] efl);
    exp_t e;
    bit   acc;
    int   n;
    e.ea = ea; e.eb = eb; e.cin = ecin; e.en = een; e.alu = alu; e.fl = efl;
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk_i);
      acc = ready_o;
      if (acc) sbq.push_back(e);
      @(posedge clk_i); #1;
      n++;
    end
    valid_i = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || pend) && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  localparam logic [63:0] ONES = '1;

  initial begin : stim
    logic [3:0]  rop [3];
    logic [63:0] ra  [3];
    logic [63:0] rb  [3];
    exp_t        re  [3];
    int          idx;
    bit          acc;
    int          exp_acc;

    reset_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_i = '0; a_i = '0; b_i = '0;
    alu_cflag_i = 1'b0; alu_vflag_i = 1'b0; alu_zflag_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_valid_o", {63'd0, valid_o}, 64'd0);
    chk("reset_flags", {61'd0, flags_o}, 64'd0);
    chk("reset_ready_o", {63'd0, ready_o}, 64'd0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_release", {63'd0, ready_o}, 64'd1);

    // ADD overflow case
    send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'b100, 3'b010, 3'b010);
    drain();

    // SUB then dependent SBC back-to-back
    send(4'd2, 64'd5, 64'd5, 64'd5, ~64'd5, 1'b1, 3'b100, 3'b101, 3'b101);
    send(4'd3, 64'd0, 64'd0, 64'd0, ONES, 1'b1, 3'b100, 3'b101, 3'b101);
    drain();

    send(4'd5, 64'hF0, 64'h0F, 64'hF0, 64'h0F, 1'b0, 3'b011, 3'b010, 3'b100);
    send(4'd1, 64'd1, 64'd2, 64'd1, 64'd2, 1'b1, 3'b100, 3'b000, 3'b000);
    send(4'd8, 64'd3, 64'd3, 64'd3, ~64'd3, 1'b1, 3'b100, 3'b101, 3'b101);
    send(4'd12, 64'h55, 64'h66, 64'd0, 64'd0, 1'b0, 3'b000, 3'b010, 3'b101);
    send(4'd7, 64'h1234, 64'h99, 64'h1234, ONES, 1'b0, 3'b010, 3'b110, 3'b100);
    send(4'd6, 64'd3, 64'd5, 64'd3, 64'd5, 1'b0, 3'b001, 3'b001, 3'b101);
    send(4'd4, 64'hC, 64'hA, 64'hC, 64'hA, 1'b0, 3'b010, 3'b000, 3'b100);
    drain();

    // Backpressure: ready_i low for 5 cycles while 3 requests are offered
    rop[0] = 4'd0; ra[0] = 64'd10;   rb[0] = 64'd20;
    rop[1] = 4'd6; ra[1] = 64'hFF;   rb[1] = 64'h0F;
    rop[2] = 4'd4; ra[2] = 64'hFF;   rb[2] = 64'hF0;
    re[0].ea = 64'd10; re[0].eb = 64'd20;  re[0].cin = 1'b0; re[0].en = 3'b100; re[0].alu = 3'b000; re[0].fl = 3'b000;
    re[1].ea = 64'hFF; re[1].eb = 64'h0F;  re[1].cin = 1'b0; re[1].en = 3'b001; re[1].alu = 3'b000; re[1].fl = 3'b000;
    re[2].ea = 64'hFF; re[2].eb = 64'hF0;  re[2].cin = 1'b0; re[2].en = 3'b010; re[2].alu = 3'b001; re[2].fl = 3'b001;
`ifdef ALU_ISSUE_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    ready_i = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      valid_i = (idx < 3);
      if (idx < 3) begin op_i = rop[idx]; a_i = ra[idx]; b_i = rb[idx]; end
      @(negedge clk_i);
      acc = ready_o && (idx < 3);
      if (acc) sbq.push_back(re[idx]);
      @(posedge clk_i); #1;
      if (acc) idx++;
    end
    chk("stall_accepted", idx, exp_acc);
    @(negedge clk_i);
    chk("stall_ready_o", {63'd0, ready_o}, 64'd0);
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    while (idx < 3) begin
      send(rop[idx], ra[idx], rb[idx], re[idx].ea, re[idx].eb, re[idx].cin, re[idx].en, re[idx].alu, re[idx].fl);
      idx++;
    end
    drain();

    // Reset while an op is stalled on the output
    ready_i = 1'b0;
    send(4'd2, 64'd1, 64'd1, 64'd1, ~64'd1, 1'b1, 3'b100, 3'b101, 3'b101);
    @(posedge clk_i); #1;
    reset_ni = 1'b0;
    sbq.delete();
    pend = 0;
    #1;
    chk("midreset_valid_o", {63'd0, valid_o}, 64'd0);
    chk("midreset_flags", {61'd0, flags_o}, 64'd0);
    chk("midreset_ready_o", {63'd0, ready_o}, 64'd0);
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("post_reset_valid_o", {63'd0, valid_o}, 64'd0);
    chk("post_reset_ready_o", {63'd0, ready_o}, 64'd1);
    send(4'd1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 3'b100, 3'b001, 3'b001);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
